// File: rtl/mult_div_unit.sv
// +--------------------------------------------------------------------------+
// | mult_div_unit : iterative 32x32 multiply/divide with HI/LO result regs.  |
// | Division support is built only with `define MULTDIV_DIV_EN. Rev 1.0      |
// +--------------------------------------------------------------------------+
`default_nettype none

module mult_div_unit (
  input  logic        Clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        wr_hi,
  input  logic        wr_lo,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        div_zero,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic [1:0] {S_IDLE, S_PREP, S_RUN, S_FIX} state_t;

  state_t      state_q, state_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [63:0] acc_q, acc_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        signed_q, signed_d;
  logic        neg_q, neg_d;
  logic        done_q, done_d;
  logic        accept;

  logic [31:0] mag_a, mag_b;
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [63:0] acc_neg;

  assign mag_a    = (signed_q && a_q[31]) ? (32'd0 - a_q) : a_q;
  assign mag_b    = (signed_q && b_q[31]) ? (32'd0 - b_q) : b_q;
  assign mul_sum  = {1'b0, acc_q[63:32]} + {1'b0, b_q};
  assign mul_next = acc_q[0] ? {mul_sum, acc_q[31:1]} : {1'b0, acc_q[63:1]};
  assign acc_neg  = 64'd0 - acc_q;

`ifdef MULTDIV_DIV_EN
  logic        is_div_q, is_div_d;
  logic        rneg_q, rneg_d;
  logic        dz_q, dz_d;
  logic [32:0] div_sh, div_diff;
  logic [63:0] div_next;

  // Restoring step: a borrow out of the 33-bit subtract means the trial failed.
  assign div_sh   = {acc_q[63:32], acc_q[31]};
  assign div_diff = div_sh - {1'b0, b_q};
  assign div_next = div_diff[32] ? {div_sh[31:0], acc_q[30:0], 1'b0}
                                 : {div_diff[31:0], acc_q[30:0], 1'b1};
  assign accept   = start;
  assign div_zero = dz_q;
`else
  assign accept   = start && !op[1];
  assign div_zero = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    signed_d = signed_q;
    neg_d    = neg_q;
    done_d   = 1'b0;
`ifdef MULTDIV_DIV_EN
    is_div_d = is_div_q;
    rneg_d   = rneg_q;
    dz_d     = dz_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (wr_hi) hi_d = wdata;
        if (wr_lo) lo_d = wdata;
        if (accept) begin
          a_d      = A;
          b_d      = B;
          signed_d = ~op[0];
          state_d  = S_PREP;
`ifdef MULTDIV_DIV_EN
          is_div_d = op[1];
          dz_d     = 1'b0;
`endif
        end
      end
      S_PREP: begin
        acc_d   = {32'd0, mag_a};
        b_d     = mag_b;
        neg_d   = signed_q && (a_q[31] ^ b_q[31]);
        cnt_d   = 6'd0;
        state_d = S_RUN;
`ifdef MULTDIV_DIV_EN
        rneg_d  = signed_q && a_q[31];
        if (is_div_q && (b_q == 32'd0)) begin
          dz_d    = 1'b1;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
`endif
      end
      S_RUN: begin
`ifdef MULTDIV_DIV_EN
        acc_d = is_div_q ? div_next : mul_next;
`else
        acc_d = mul_next;
`endif
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) state_d = S_FIX;
      end
      S_FIX: begin
        {hi_d, lo_d} = neg_q ? acc_neg : acc_q;
`ifdef MULTDIV_DIV_EN
        // Quotient and remainder carry independent signs.
        if (is_div_q) begin
          lo_d = neg_q  ? (32'd0 - acc_q[31:0])  : acc_q[31:0];
          hi_d = rneg_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];
        end
`endif
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      acc_q    <= 64'd0;
      cnt_q    <= 6'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      signed_q <= 1'b0;
      neg_q    <= 1'b0;
      done_q   <= 1'b0;
`ifdef MULTDIV_DIV_EN
      is_div_q <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      signed_q <= signed_d;
      neg_q    <= neg_d;
      done_q   <= done_d;
`ifdef MULTDIV_DIV_EN
      is_div_q <= is_div_d;
      rneg_q   <= rneg_d;
      dz_q     <= dz_d;
`endif
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit; expected HI/LO come from plain 64-bit arithmetic.
`default_nettype none

module tb_mult_div_unit;

  logic        Clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] A = 32'd0, B = 32'd0;
  logic        wr_hi = 1'b0, wr_lo = 1'b0;
  logic [31:0] wdata = 32'd0;
  logic        busy, done, div_zero;
  logic [31:0] HI, LO;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] m_hi = 32'd0, m_lo = 32'd0;

  mult_div_unit dut (
    .Clk(Clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
    .wr_hi(wr_hi), .wr_lo(wr_lo), .wdata(wdata),
    .busy(busy), .done(done), .div_zero(div_zero), .HI(HI), .LO(LO)
  );

  always #5 Clk = ~Clk;

  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a,
                                        input logic [31:0] b, input logic [63:0] prev);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = $signed(a);
    sb = $signed(b);
    case (o)
      2'b00: begin p = sa * sb; return p; end
      2'b01: begin p = {32'd0, a} * {32'd0, b}; return p; end
      2'b10: begin
        if (b == 32'd0) return prev;
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 32'd0) return prev;
        return {a % b, a / b};
      end
    endcase
  endfunction

  // mode 0: plain; 1: start and MTHI/MTLO pulsed while busy; 2: MTHI in the start cycle
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input int mode, input string name);
    logic [63:0] exp;
    int exp_lat, k, busy_cnt;
    bit is_dz;
    is_dz   = o[1] && (b == 32'd0);
    exp_lat = is_dz ? 1 : 34;
    start = 1'b1; op = o; A = a; B = b;
    if (mode == 2) begin wr_hi = 1'b1; wdata = 32'h99; m_hi = 32'h99; end
    exp = model(o, a, b, {m_hi, m_lo});
    @(posedge Clk); #1;
    start = 1'b0; wr_hi = 1'b0;
    A = $urandom; B = $urandom; op = 2'($urandom);
    if (mode == 2) begin
      n_checks++;
      if (HI !== 32'h99) begin n_fail++; $display("FAIL %s same_cycle_mthi HI=%h want 00000099", name, HI); end
    end
    n_checks++;
    if (div_zero !== 1'b0) begin n_fail++; $display("FAIL %s dz_clear got=%b want 0", name, div_zero); end
    k = 0; busy_cnt = 0;
    while (done !== 1'b1 && k < 60) begin
      if (busy === 1'b1) busy_cnt++;
      if (mode == 1) begin
        if (k == 5) begin start = 1'b1; op = 2'b01; A = 32'd1; B = 32'd1; end
        if (k == 6) start = 1'b0;
        if (k == 8) begin wr_hi = 1'b1; wr_lo = 1'b1; wdata = 32'hDEAD; end
        if (k == 9) begin wr_hi = 1'b0; wr_lo = 1'b0; end
      end
      @(posedge Clk); #1; k++;
    end
    n_checks++;
    if (k != exp_lat) begin n_fail++; $display("FAIL %s latency got=%0d want %0d", name, k, exp_lat); end
    n_checks++;
    if (busy_cnt != exp_lat) begin n_fail++; $display("FAIL %s busy_cycles got=%0d want %0d", name, busy_cnt, exp_lat); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL %s busy_at_done got=%b want 0", name, busy); end
    n_checks++;
    if ({HI, LO} !== exp) begin n_fail++; $display("FAIL %s result HI:LO=%h:%h want %h:%h", name, HI, LO, exp[63:32], exp[31:0]); end
    n_checks++;
    if (div_zero !== is_dz) begin n_fail++; $display("FAIL %s div_zero got=%b want %b", name, div_zero, is_dz); end
    {m_hi, m_lo} = exp;
    @(posedge Clk); #1;
    n_checks++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL %s done_width got=%b want 0", name, done); end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    n_checks++;
    if ({busy, done, div_zero} !== 3'b000) begin n_fail++; $display("FAIL reset flags busy/done/dz=%b want 000", {busy, done, div_zero}); end
    n_checks++;
    if ({HI, LO} !== 64'd0) begin n_fail++; $display("FAIL reset HI:LO=%h:%h want 0:0", HI, LO); end
    m_hi = 32'd0; m_lo = 32'd0;
    reset = 1'b1;
    @(posedge Clk); #1;
  endtask

  task automatic write_hilo(input logic [31:0] h, input logic [31:0] l);
    wr_hi = 1'b1; wdata = h;
    @(posedge Clk); #1;
    wr_hi = 1'b0; wr_lo = 1'b1; wdata = l;
    @(posedge Clk); #1;
    wr_lo = 1'b0;
    m_hi = h; m_lo = l;
  endtask

  task automatic test_mthi_mtlo();
    write_hilo(32'h11, 32'h22);
    n_checks++;
    if ({HI, LO} !== {32'h11, 32'h22}) begin n_fail++; $display("FAIL mtx_separate HI:LO=%h:%h want 11:22", HI, LO); end
    wr_hi = 1'b1; wr_lo = 1'b1; wdata = 32'hABCD1234;
    @(posedge Clk); #1;
    wr_hi = 1'b0; wr_lo = 1'b0;
    m_hi = 32'hABCD1234; m_lo = 32'hABCD1234;
    n_checks++;
    if ({HI, LO} !== {m_hi, m_lo}) begin n_fail++; $display("FAIL mtx_both HI:LO=%h:%h want %h:%h", HI, LO, m_hi, m_lo); end
  endtask

  task automatic test_mult();
    do_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, "multu_max");
    n_checks++;
    if ({HI, LO} !== {32'hFFFFFFFE, 32'h00000001}) begin n_fail++; $display("FAIL multu_max_const HI:LO=%h:%h want fffffffe:00000001", HI, LO); end
    do_op(2'b00, 32'h80000000, 32'h80000000, 0, "mult_minmin");
    do_op(2'b00, 32'hFFFFFFF9, 32'd3, 0, "mult_neg7x3");
    n_checks++;
    if ({HI, LO} !== {32'hFFFFFFFF, 32'hFFFFFFEB}) begin n_fail++; $display("FAIL mult_neg7x3_const HI:LO=%h:%h want ffffffff:ffffffeb", HI, LO); end
    do_op(2'b01, 32'd2, 32'd3, 2, "start_with_mthi");
    for (int i = 0; i < 8; i++)
      do_op({1'b0, 1'($urandom)}, $urandom, $urandom, 0, "mult_rand");
  endtask

`ifdef MULTDIV_DIV_EN
  task automatic test_div();
    logic [31:0] b;
    do_op(2'b10, 32'hFFFFFFF9, 32'd2, 0, "div_neg7_2");
    do_op(2'b11, 32'd100, 32'd7, 0, "divu_100_7");
    n_checks++;
    if ({HI, LO} !== {32'd2, 32'd14}) begin n_fail++; $display("FAIL divu_const HI:LO=%h:%h want 2:14", HI, LO); end
    do_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 0, "div_overflow");
    write_hilo(32'h11, 32'h22);
    do_op(2'b10, 32'd55, 32'd0, 0, "div_by_zero");
    n_checks++;
    if ({HI, LO} !== {32'h11, 32'h22}) begin n_fail++; $display("FAIL dz_hold HI:LO=%h:%h want 11:22", HI, LO); end
    do_op(2'b11, 32'd100, 32'd7, 0, "after_dz");
    for (int i = 0; i < 8; i++) begin
      b = (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
      if ($signed(b) == -1 && i % 2 == 1) b = 32'd3;
      do_op({1'b1, 1'($urandom)}, $urandom, b, 0, "div_rand");
    end
  endtask
`else
  task automatic test_div_disabled();
    int busy_cnt, done_cnt;
    start = 1'b1; op = 2'b11; A = 32'd100; B = 32'd7;
    busy_cnt = 0; done_cnt = 0;
    @(posedge Clk); #1;
    start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) done_cnt++;
      @(posedge Clk); #1;
    end
    n_checks++;
    if (busy_cnt != 0) begin n_fail++; $display("FAIL nodiv_busy cycles=%0d want 0", busy_cnt); end
    n_checks++;
    if (done_cnt != 0) begin n_fail++; $display("FAIL nodiv_done pulses=%0d want 0", done_cnt); end
    n_checks++;
    if ({HI, LO} !== {m_hi, m_lo}) begin n_fail++; $display("FAIL nodiv_hold HI:LO=%h:%h want %h:%h", HI, LO, m_hi, m_lo); end
    do_op(2'b01, 32'd6, 32'd7, 0, "multu_6x7");
  endtask
`endif

  task automatic test_hazards();
    do_op(2'b00, 32'h12345678, 32'hFEDCBA98, 1, "busy_hazards");
  endtask

  task automatic test_mid_reset();
    int done_cnt;
    write_hilo(32'h55, 32'h66);
    start = 1'b1; op = 2'b01; A = 32'hFFFFFFFF; B = 32'hFFFFFFFF;
    @(posedge Clk); #1;
    start = 1'b0;
    repeat (10) begin @(posedge Clk); #1; end
    reset = 1'b0;
    @(posedge Clk); #1;
    reset = 1'b1;
    m_hi = 32'd0; m_lo = 32'd0;
    n_checks++;
    if ({busy, done, div_zero} !== 3'b000) begin n_fail++; $display("FAIL midreset_flags busy/done/dz=%b want 000", {busy, done, div_zero}); end
    n_checks++;
    if ({HI, LO} !== 64'd0) begin n_fail++; $display("FAIL midreset_hilo HI:LO=%h:%h want 0:0", HI, LO); end
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1 || busy === 1'b1) done_cnt++;
      @(posedge Clk); #1;
    end
    n_checks++;
    if (done_cnt != 0) begin n_fail++; $display("FAIL midreset_quiet active_cycles=%0d want 0", done_cnt); end
    do_op(2'b01, 32'd3, 32'd5, 0, "multu_3x5");
    n_checks++;
    if (LO !== 32'd15) begin n_fail++; $display("FAIL multu_3x5_const LO=%h want 0000000f", LO); end
  endtask

  initial begin
    @(posedge Clk); #1;
    test_reset();
    test_mthi_mtlo();
    test_mult();
`ifdef MULTDIV_DIV_EN
    test_div();
`else
    test_div_disabled();
`endif
    test_hazards();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
